// File: rtl/ball_draw_sequencer.sv
// Ball draw sequencer: on each accepted frame_tick it erases the ball at its
// previous position in the background colour, then draws it at the new
// position in the ball colour, driving the square-draw engine handshake and
// counting the engine's pixel writes to know when each pass has finished.
module ball_draw_sequencer #(
  parameter int                   SIZE_W    = 10,
  parameter int                   COLOUR_W  = 3,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = '0,
  parameter int                   GO_HOLD   = 2,
  parameter int                   TO_SLACK  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic [SIZE_W-1:0]   new_x,
  input  logic [SIZE_W-1:0]   new_y,
  input  logic [SIZE_W-1:0]   size,
  input  logic [COLOUR_W-1:0] ball_colour,
  input  logic                eng_wren,
  output logic                eng_go,
  output logic [SIZE_W-1:0]   eng_x,
  output logic [SIZE_W-1:0]   eng_y,
  output logic [SIZE_W-1:0]   eng_size,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                timeout
);

  localparam int PIX_W = 2 * SIZE_W;
  // One extra bit so the watchdog limit cannot wrap for the largest square.
  localparam int WD_W  = PIX_W + 1;
  localparam int GO_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_GO,
    ERASE_WAIT,
    DRAW_GO,
    DRAW_WAIT,
    DONE
  } state_t;

  state_t state, state_next;

  // Values captured on the accepted tick (the pass about to be drawn).
  logic [SIZE_W-1:0]   lat_x, lat_y, lat_size;
  logic [COLOUR_W-1:0] lat_colour;
  // Position of the square currently on screen (erase target).
  logic [SIZE_W-1:0]   old_x, old_y, old_size;
  logic                old_valid;

  logic [PIX_W-1:0] pix_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [GO_W-1:0]  go_cnt;

  logic              in_erase, in_draw, in_go, in_wait;
  logic [SIZE_W-1:0] pass_size;
  logic [PIX_W-1:0]  pass_sq;
  logic [WD_W-1:0]   wd_limit;
  logic              pix_done, wd_expired, go_last, timeout_hit, entering_go;

  // Pass-level decode: which square is being worked on and its completion targets.
  always_comb begin
    in_erase    = (state == ERASE_GO) || (state == ERASE_WAIT);
    in_draw     = (state == DRAW_GO)  || (state == DRAW_WAIT);
    in_go       = (state == ERASE_GO) || (state == DRAW_GO);
    in_wait     = (state == ERASE_WAIT) || (state == DRAW_WAIT);
    pass_size   = in_erase ? old_size : (in_draw ? lat_size : '0);
    pass_sq     = PIX_W'(pass_size) * PIX_W'(pass_size);
    wd_limit    = WD_W'(pass_sq) + WD_W'({pass_size, 1'b0}) + WD_W'(GO_HOLD + TO_SLACK);
    pix_done    = (pix_cnt == pass_sq);
    wd_expired  = (wd_cnt >= wd_limit);
    go_last     = (go_cnt == GO_W'(GO_HOLD - 1));
    timeout_hit = in_wait && !pix_done && wd_expired;
  end

  // Next-state logic for the erase/draw sequence.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can infer a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          if (size == '0)     state_next = DONE;
          else if (old_valid) state_next = ERASE_GO;
          else                state_next = DRAW_GO;
        end
      end
      ERASE_GO:   if (go_last) state_next = ERASE_WAIT;
      ERASE_WAIT: begin
        if (pix_done)         state_next = DRAW_GO;
        else if (timeout_hit) state_next = DONE;
      end
      DRAW_GO:    if (go_last) state_next = DRAW_WAIT;
      DRAW_WAIT: begin
        if (pix_done || timeout_hit) state_next = DONE;
      end
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    entering_go = ((state_next == ERASE_GO) || (state_next == DRAW_GO)) && (state_next != state);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Latched request, on-screen position, pass counters and sticky flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lat_x      <= '0;
      lat_y      <= '0;
      lat_size   <= '0;
      lat_colour <= '0;
      old_x      <= '0;
      old_y      <= '0;
      old_size   <= '0;
      old_valid  <= 1'b0;
      pix_cnt    <= '0;
      wd_cnt     <= '0;
      go_cnt     <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (state == IDLE && frame_tick) begin
        lat_x      <= new_x;
        lat_y      <= new_y;
        lat_size   <= size;
        lat_colour <= ball_colour;
      end
      if (state != IDLE && frame_tick) overrun <= 1'b1;
      if (timeout_hit)                 timeout <= 1'b1;
      if (state == DONE) begin
        old_x     <= lat_x;
        old_y     <= lat_y;
        old_size  <= lat_size;
        old_valid <= 1'b1;
      end
      if (entering_go) begin
        pix_cnt <= '0;
        wd_cnt  <= '0;
        go_cnt  <= '0;
      end else begin
        if (in_go || in_wait)    wd_cnt  <= wd_cnt + 1'b1;
        if (in_go)               go_cnt  <= go_cnt + 1'b1;
        if (in_wait && eng_wren) pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // Engine-facing outputs decoded from state; coordinates stay fixed for the whole pass.
  always_comb begin
    eng_go     = in_go && (pass_size != '0);
    eng_x      = '0;
    eng_y      = '0;
    eng_size   = pass_size;
    colour_out = '0;
    if (in_erase) begin
      eng_x      = old_x;
      eng_y      = old_y;
      colour_out = BG_COLOUR;
    end else if (in_draw) begin
      eng_x      = lat_x;
      eng_y      = lat_y;
      colour_out = lat_colour;
    end
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_ball_draw_sequencer.sv
// Directed bench for ball_draw_sequencer with a behavioural square-draw
// engine that answers each go with size*size consecutive write pulses.
module tb_ball_draw_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [9:0] new_x, new_y, size;
  logic [2:0] ball_colour;
  logic       eng_wren;
  logic       eng_go;
  logic [9:0] eng_x, eng_y, eng_size;
  logic [2:0] colour_out;
  logic       busy, done, overrun, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Engine model state.
  int   pend  = 0;
  logic stall = 1'b0;

  // Monitor counters and expected pass positions.
  int         erase_wr, draw_wr, go_cyc, done_cnt, pos_err, col_err;
  logic [9:0] exp_ex, exp_ey, exp_dx, exp_dy;
  logic [2:0] exp_col;

  ball_draw_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .new_x       (new_x),
    .new_y       (new_y),
    .size        (size),
    .ball_colour (ball_colour),
    .eng_wren    (eng_wren),
    .eng_go      (eng_go),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_size    (eng_size),
    .colour_out  (colour_out),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Engine: while go is high it loads size*size, then emits one write per cycle.
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      pend     = 0;
      eng_wren = 1'b0;
    end else if (eng_go) begin
      pend     = int'(eng_size) * int'(eng_size);
      eng_wren = 1'b0;
    end else if (pend > 0 && !stall) begin
      eng_wren = 1'b1;
      pend     = pend - 1;
    end else begin
      eng_wren = 1'b0;
    end
  end

  // Monitor: classify pixel writes by colour and check the coordinates they use.
  always @(negedge clk) begin
    if (eng_wren) begin
      if (colour_out == 3'd0) begin
        erase_wr++;
        if (eng_x != exp_ex || eng_y != exp_ey) pos_err++;
      end else begin
        draw_wr++;
        if (eng_x != exp_dx || eng_y != exp_dy) pos_err++;
        if (colour_out != exp_col) col_err++;
      end
    end
    if (eng_go) go_cyc++;
    if (done)   done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk);
    erase_wr = 0; draw_wr = 0; go_cyc = 0; done_cnt = 0; pos_err = 0; col_err = 0;
  endtask

  // Present a one-cycle tick; returns at the negedge just after the accepting edge.
  task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s,
                      input logic [2:0] c);
    @(negedge clk);
    new_x = x; new_y = y; size = s; ball_colour = c; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; new_x = '0; new_y = '0; size = '0; ball_colour = '0;
    eng_wren = 1'b0;
    erase_wr = 0; draw_wr = 0; go_cyc = 0; done_cnt = 0; pos_err = 0; col_err = 0;
    exp_ex = '0; exp_ey = '0; exp_dx = '0; exp_dy = '0; exp_col = '0;
    repeat (3) @(negedge clk);
    check("rst_go", 32'(eng_go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {30'd0, overrun, timeout}, 32'd0);
    check("rst_bus", {eng_x, eng_y, eng_size, colour_out}, 32'd0);
    resetn = 1'b1;

    // 1: first tick after reset draws only.
    clear_counts();
    exp_dx = 10'd10; exp_dy = 10'd20; exp_col = 3'd5;
    tick(10'd10, 10'd20, 10'd4, 3'd5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_go", 32'(eng_go), 32'd1);
    check("t1_xy", {eng_x, eng_y, eng_size}, {2'd0, 10'd10, 10'd20, 10'd4});
    check("t1_col", 32'(colour_out), 32'd5);
    wait_done("t1", 100);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_draw_wr", 32'(draw_wr), 32'd16);
    check("t1_erase_wr", 32'(erase_wr), 32'd0);
    check("t1_go_cyc", 32'(go_cyc), 32'd2);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_pos_col_err", 32'(pos_err + col_err), 32'd0);

    // 2: second tick erases the old square, then draws the new one.
    clear_counts();
    exp_ex = 10'd10; exp_ey = 10'd20; exp_dx = 10'd30; exp_dy = 10'd40; exp_col = 3'd5;
    tick(10'd30, 10'd40, 10'd4, 3'd5);
    check("t2_erase_x", 32'(eng_x), 32'd10);
    check("t2_erase_col", 32'(colour_out), 32'd0);
    wait_done("t2", 200);
    check("t2_erase_wr", 32'(erase_wr), 32'd16);
    check("t2_draw_wr", 32'(draw_wr), 32'd16);
    check("t2_go_cyc", 32'(go_cyc), 32'd4);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_pos_col_err", 32'(pos_err + col_err), 32'd0);

    // 3: size 0 goes straight to DONE; the following erase of a size-0 square has no go.
    clear_counts();
    tick(10'd50, 10'd60, 10'd0, 3'd2);
    check("t3_done_now", 32'(done), 32'd1);
    check("t3_go_now", 32'(eng_go), 32'd0);
    @(negedge clk);
    check("t3_busy_after", 32'(busy), 32'd0);
    check("t3_go_cyc", 32'(go_cyc), 32'd0);
    clear_counts();
    exp_ex = 10'd50; exp_ey = 10'd60; exp_dx = 10'd70; exp_dy = 10'd80; exp_col = 3'd6;
    tick(10'd70, 10'd80, 10'd2, 3'd6);
    check("t3b_erase_x", 32'(eng_x), 32'd50);
    check("t3b_erase_go", 32'(eng_go), 32'd0);
    wait_done("t3b", 100);
    check("t3b_go_cyc", 32'(go_cyc), 32'd2);
    check("t3b_erase_wr", 32'(erase_wr), 32'd0);
    check("t3b_draw_wr", 32'(draw_wr), 32'd4);
    check("t3b_pos_col_err", 32'(pos_err + col_err), 32'd0);

    // 4: tick during the draw pass sets overrun without disturbing the pass.
    clear_counts();
    check("t4_overrun_before", 32'(overrun), 32'd0);
    exp_ex = 10'd70; exp_ey = 10'd80; exp_dx = 10'd100; exp_dy = 10'd110; exp_col = 3'd1;
    tick(10'd100, 10'd110, 10'd3, 3'd1);
    for (int i = 0; i < 100 && draw_wr < 3; i++) @(posedge clk);
    check("t4_reached_draw", 32'(draw_wr >= 3), 32'd1);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("t4_overrun", 32'(overrun), 32'd1);
    wait_done("t4", 100);
    check("t4_erase_wr", 32'(erase_wr), 32'd4);
    check("t4_draw_wr", 32'(draw_wr), 32'd9);
    repeat (3) @(negedge clk);
    #1;
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_pos_col_err", 32'(pos_err + col_err), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);

    // 5: stalled engine, old size 3 -> watchdog limit 9+6+2+16 = 33 cycles.
    clear_counts();
    stall = 1'b1;
    tick(10'd5, 10'd5, 10'd3, 3'd3);
    repeat (33) @(negedge clk);
    check("t5_timeout_early", 32'(timeout), 32'd0);
    @(negedge clk);
    check("t5_timeout", 32'(timeout), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    @(negedge clk);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_writes", 32'(erase_wr + draw_wr), 32'd0);
    stall = 1'b0;

    // 6: reset during the erase pass, then a draw-only pass.
    clear_counts();
    exp_ex = 10'd5; exp_ey = 10'd5; exp_dx = 10'd200; exp_dy = 10'd210; exp_col = 3'd7;
    tick(10'd200, 10'd210, 10'd2, 3'd7);
    for (int i = 0; i < 100 && erase_wr < 2; i++) @(posedge clk);
    check("t6_in_erase", 32'(erase_wr >= 2), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_go_busy_done", {29'd0, eng_go, busy, done}, 32'd0);
    check("t6_rst_flags", {30'd0, overrun, timeout}, 32'd0);
    check("t6_rst_bus", {eng_x, eng_y, eng_size, colour_out}, 32'd0);
    resetn = 1'b1;
    clear_counts();
    exp_dx = 10'd1; exp_dy = 10'd2; exp_col = 3'd4;
    tick(10'd1, 10'd2, 10'd2, 3'd4);
    check("t6_draw_x", 32'(eng_x), 32'd1);
    check("t6_draw_col", 32'(colour_out), 32'd4);
    wait_done("t6", 100);
    check("t6_erase_wr", 32'(erase_wr), 32'd0);
    check("t6_draw_wr", 32'(draw_wr), 32'd4);
    check("t6_go_cyc", 32'(go_cyc), 32'd2);
    check("t6_pos_col_err", 32'(pos_err + col_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
